aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
Round sequencer sitting directly upstream of the round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey wrapper). Accepts one plaintext block and the 176-byte expanded key. Drives the datapath's enable, initial-round, final-round and done controls. Steps the datapath through round 0 (AddRoundKey only), rounds 1..NUM_ROUNDS-1 (full) and round NUM_ROUNDS (no MixColumns), supplying the matching 16-byte round key each round, then presents the ciphertext.

Parameters:
NUM_ROUNDS, 10, number of cipher rounds after the initial AddRoundKey (AES-128).
TIMEOUT_CYCLES, 64, maximum cycles to wait for datapath completion in one round before aborting; counter width ceil(log2(TIMEOUT_CYCLES+1)).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  request encryption; sampled only in IDLE
plaintext  in  [0:127]  16-byte input block, captured on accepted start
expandedKey  in  [0:128*(NUM_ROUNDS+1)-1]  expanded key; round r key = bits [128*r : 128*r+127]; must be stable while busy
roundMessage  in  [0:127]  datapath result (datapath messageOut)
roundDone  in  1  datapath completion (datapath roundsDone)
enableRounds  out  1  datapath enable
initialRound  out  1  high during round 0
finalRound  out  1  high during round NUM_ROUNDS
done  out  1  to datapath done input; high in FINISH
messageIn  out  [0:127]  datapath state input
newKey  out  [0:127]  current round key
ciphertext  out  [0:127]  result, held until next accepted start
busy  out  1  high from accepted start until FINISH exits
valid  out  1  one-cycle pulse, ciphertext valid
error  out  1  sticky timeout flag, cleared on next accepted start

Behaviour:
- Reset (rst low, async): state IDLE, round counter 0, state register 0, ciphertext 0, all 1-bit outputs 0, timeout counter 0. Reset mid-encryption aborts immediately; no valid pulse.
- States: IDLE, RUN, GAP, FINISH.
- IDLE: busy=0. On start=1: latch plaintext into state register, round<=0, error<=0, go to RUN. start while busy is ignored.
- RUN: enableRounds=1; initialRound=(round==0); finalRound=(round==NUM_ROUNDS); messageIn=state register; newKey=expandedKey slice for round. Timeout counter increments each cycle.
  - roundDone=1: state register<=roundMessage; enableRounds drops next cycle; timeout counter cleared; go to GAP.
  - If the counter reaches TIMEOUT_CYCLES without roundDone: error<=1, go to IDLE, no valid.
- GAP: enableRounds=0; initialRound/finalRound hold the just-finished round's values; wait for roundDone=0, with minimum dwell 1 cycle.
  - If round==NUM_ROUNDS: go to FINISH.
  - Else round<=round+1, go to RUN.
  - GAP waits also count toward the timeout.
- FINISH, exactly 1 cycle: done=1, ciphertext<=state register, valid=1, busy=0 next cycle, go to IDLE.
- roundDone outside RUN is ignored.
- Round counter width ceil(log2(NUM_ROUNDS+1)). No wrap: the counter never exceeds NUM_ROUNDS.
- Output timing: controls are registered outputs of the state and round counter. newKey and messageIn are combinational from registers, glitch-free within a round.
- Latency: 1 (start) + sum over NUM_ROUNDS+1 rounds of (datapath latency + GAP dwell) + 1 (FINISH).

Test Plan:
- FIPS-197 App. B with behavioural or real datapath: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c expanded -> single valid pulse, ciphertext 3925841d02dc09fbdc118597196a0b32, busy low after.
- Control sequence check, same run:
  - initialRound high only while round=0.
  - finalRound high only while round=10.
  - exactly 11 enableRounds high periods, each separated by ≥1 low cycle.
  - newKey equals key slice r in round r.
- start pulsed at cycle 5 of an encryption with a different plaintext -> ignored; result still the App. B ciphertext; second start after valid accepted normally.
- Datapath model withholds roundDone in round 4 -> error=1 after 64 cycles, return to IDLE, no valid; next start clears error and completes correctly.
- rst driven low asynchronously (between edges) during round 6 -> all outputs 0 immediately, ciphertext 0; after release, fresh start yields correct ciphertext.
- roundDone held high for 3 cycles per round -> GAP waits; each round captured exactly once; ciphertext still correct.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences an AES round datapath through the initial
// AddRoundKey round, the full rounds and the final round (no MixColumns),
// supplying each round key, then presents the ciphertext.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   start, plaintext   encryption request and input block (taken in IDLE only)
//   expandedKey        all round keys, round r at bits [128*r +: 128]
//   roundMessage       datapath result, captured when roundDone is seen in RUN
//   roundDone          datapath completion
//   enableRounds       datapath enable (high for the whole of each round)
//   initialRound       high during round 0
//   finalRound         high during the last round
//   done               high for the single FINISH cycle
//   messageIn, newKey  datapath state and round key (combinational from registers)
//   ciphertext, valid  result and its one-cycle qualifier
//   busy               high from accepted start until FINISH is left
//   error              sticky datapath-timeout flag, cleared on the next start
module aes_round_ctrl #(
  parameter int unsigned NUM_ROUNDS     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [0:127]                      plaintext,
  input  logic [0:128*(NUM_ROUNDS+1)-1]     expandedKey,
  input  logic [0:127]                      roundMessage,
  input  logic                              roundDone,
  output logic                              enableRounds,
  output logic                              initialRound,
  output logic                              finalRound,
  output logic                              done,
  output logic [0:127]                      messageIn,
  output logic [0:127]                      newKey,
  output logic [0:127]                      ciphertext,
  output logic                              busy,
  output logic                              valid,
  output logic                              error
);

  localparam int unsigned BLK_W = 128;
  localparam int unsigned RND_W = $clog2(NUM_ROUNDS + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, GAP, FINISH} fsm_t;

  fsm_t             fsm;
  logic [RND_W-1:0] round;
  logic [TMO_W-1:0] tcnt;
  logic [0:BLK_W-1] blk;
  logic [TMO_W-1:0] tcnt_inc;
  logic             tmo_hit;

  // Timeout fires on the cycle the wait count would reach the limit.
  assign tcnt_inc = tcnt + TMO_W'(1);
  assign tmo_hit  = (tcnt_inc == TMO_LIM);

  // Datapath operands come straight from registers so they are stable all round.
  assign messageIn = blk;
  assign newKey    = expandedKey[BLK_W * 32'(round) +: BLK_W];

  // Round sequencer with registered controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm          <= IDLE;
      round        <= '0;
      tcnt         <= '0;
      blk          <= '0;
      ciphertext   <= '0;
      enableRounds <= 1'b0;
      initialRound <= 1'b0;
      finalRound   <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      valid        <= 1'b0;
      error        <= 1'b0;
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      unique case (fsm)
        IDLE: begin
          if (start) begin
            blk          <= plaintext;
            round        <= '0;
            tcnt         <= '0;
            error        <= 1'b0;
            busy         <= 1'b1;
            enableRounds <= 1'b1;
            initialRound <= 1'b1;
            finalRound   <= (LAST_RND == RND_W'(0));
            fsm          <= RUN;
          end
        end
        RUN: begin
          if (roundDone) begin
            blk          <= roundMessage;
            enableRounds <= 1'b0;
            tcnt         <= '0;
            fsm          <= GAP;
          end else if (tmo_hit) begin
            error        <= 1'b1;
            busy         <= 1'b0;
            enableRounds <= 1'b0;
            initialRound <= 1'b0;
            finalRound   <= 1'b0;
            tcnt         <= '0;
            fsm          <= IDLE;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        GAP: begin
          // Wait for the datapath to drop roundDone so one round is never captured twice.
          if (!roundDone) begin
            tcnt <= '0;
            if (round == LAST_RND) begin
              initialRound <= 1'b0;
              finalRound   <= 1'b0;
              ciphertext   <= blk;
              done         <= 1'b1;
              valid        <= 1'b1;
              fsm          <= FINISH;
            end else begin
              round        <= round + RND_W'(1);
              enableRounds <= 1'b1;
              initialRound <= 1'b0;
              finalRound   <= ((round + RND_W'(1)) == LAST_RND);
              fsm          <= RUN;
            end
          end else if (tmo_hit) begin
            error        <= 1'b1;
            busy         <= 1'b0;
            enableRounds <= 1'b0;
            initialRound <= 1'b0;
            finalRound   <= 1'b0;
            tcnt         <= '0;
            fsm          <= IDLE;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        FINISH: begin
          busy <= 1'b0;
          fsm  <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: drives aes_round_ctrl with a behavioural AES round
// datapath and checks results against FIPS-197 vectors and a reference cipher.
module tb_aes_round_ctrl;

  localparam int unsigned NR    = 10;
  localparam int unsigned TMO   = 64;
  localparam int unsigned KEY_W = 128 * (NR + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [0:127]       plaintext;
  logic [0:KEY_W-1]   expandedKey;
  logic [0:127]       roundMessage;
  logic               roundDone;
  logic               enableRounds, initialRound, finalRound, done;
  logic [0:127]       messageIn, newKey, ciphertext;
  logic               busy, valid, error;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NUM_ROUNDS(NR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .plaintext(plaintext),
    .expandedKey(expandedKey), .roundMessage(roundMessage), .roundDone(roundDone),
    .enableRounds(enableRounds), .initialRound(initialRound), .finalRound(finalRound),
    .done(done), .messageIn(messageIn), .newKey(newKey), .ciphertext(ciphertext),
    .busy(busy), .valid(valid), .error(error)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int n_valid = 0;
  int en_periods = 0;
  int en_idx = 0;
  int en_len = 0;
  int dp_lat = 1;
  int dp_hold = 1;
  bit withhold = 1'b0;
  logic [0:127] exp_q [$];
  logic [0:127] rk_cur [0:NR];
  logic [7:0]   sbox_t [256];

  typedef struct {
    logic [0:127] pt;
    logic [0:127] key;
    int           lat;
    int           hold;
    logic [0:127] ct;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference AES-128 ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] x = 8'(i);
      logic [7:0] inv = 8'h00;
      if (x != 8'h00) begin
        inv = 8'h01;
        repeat (254) inv = gmul(inv, x);
      end
      sbox_t[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [0:127] sub_shift(input logic [0:127] s);
    logic [0:127] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r + 4*c) +: 8] = sbox_t[s[8*(r + 4*((c + r) % 4)) +: 8]];
    return o;
  endfunction

  function automatic logic [0:127] mix(input logic [0:127] s);
    logic [0:127] o;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0 = s[8*(4*c)     +: 8];
      logic [7:0] a1 = s[8*(4*c + 1) +: 8];
      logic [7:0] a2 = s[8*(4*c + 2) +: 8];
      logic [7:0] a3 = s[8*(4*c + 3) +: 8];
      o[8*(4*c)     +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[8*(4*c + 1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[8*(4*c + 2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[8*(4*c + 3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [0:127] aes_round(input logic [0:127] msg, input logic [0:127] key,
                                             input logic ini, input logic fin);
    logic [0:127] t;
    if (ini) return msg ^ key;
    t = sub_shift(msg);
    if (!fin) t = mix(t);
    return t ^ key;
  endfunction

  function automatic logic [0:KEY_W-1] expand(input logic [0:127] key);
    logic [31:0] w [0:4*(NR+1)-1];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [0:KEY_W-1] e;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 4*(NR+1); i++) e[32*i +: 32] = w[i];
    return e;
  endfunction

  function automatic logic [0:127] ref_encrypt(input logic [0:127] pt, input logic [0:KEY_W-1] ek);
    logic [0:127] s = aes_round(pt, ek[0 +: 128], 1'b1, 1'b0);
    for (int r = 1; r <= int'(NR); r++) s = aes_round(s, ek[128*r +: 128], 1'b0, r == int'(NR));
    return s;
  endfunction

  // ---------------- behavioural datapath ----------------
  initial begin
    int cnt = 0;
    roundDone = 1'b0;
    roundMessage = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        roundDone = 1'b0;
        cnt = 0;
      end else if (roundDone) begin
        if (cnt >= dp_hold) begin
          roundDone = 1'b0;
          cnt = 0;
        end else cnt++;
      end else if (enableRounds && !(withhold && newKey == rk_cur[4])) begin
        cnt++;
        if (cnt >= dp_lat) begin
          roundMessage = aes_round(messageIn, newKey, initialRound, finalRound);
          roundDone = 1'b1;
          cnt = 1;
        end
      end else cnt = 0;
    end
  end

  // ---------------- control monitor and scoreboard ----------------
  initial begin
    logic prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) prev_en = 1'b0;
      else begin
        if (enableRounds) begin
          if (!prev_en) begin
            en_idx = en_periods;
            en_periods++;
            en_len = 0;
          end
          en_len++;
          if (en_idx > int'(NR)) chk("round_count", en_idx, NR);
          else chk("round_ctrl", {initialRound, finalRound, newKey},
                   {en_idx == 0, en_idx == int'(NR), rk_cur[en_idx]});
        end
        prev_en = enableRounds;
        if (valid) begin
          n_valid++;
          chk("finish_flags", {done, busy}, 2'b11);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_valid: got ciphertext %h with no expected result", ciphertext);
          end else chk("ciphertext", ciphertext, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic load_key(input logic [0:127] key);
    expandedKey = expand(key);
    for (int r = 0; r <= int'(NR); r++) rk_cur[r] = expandedKey[128*r +: 128];
  endtask

  task automatic start_enc(input logic [0:127] pt, input logic [0:127] ct, input bit push);
    @(negedge clk);
    if (push) exp_q.push_back(ct);
    en_periods = 0;
    start = 1'b1;
    plaintext = pt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_enc();
    int n0 = n_valid;
    int k = 0;
    while (n_valid == n0 && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("valid_seen", n_valid != n0, 1'b1);
    chk("round_periods", en_periods, NR + 1);
    @(negedge clk); #1;
    chk("after_finish", {busy, valid, done}, 3'b000);
  endtask

  localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    logic [0:127] pt_r;
    int k;
    rst = 1'b0;
    start = 1'b0;
    plaintext = '0;
    expandedKey = '0;
    build_sbox();

    tbl[0] = '{pt: PT_B, key: KEY_B, lat: 1, hold: 1, ct: CT_B};
    tbl[1] = '{pt: 128'h00112233445566778899aabbccddeeff, key: 128'h000102030405060708090a0b0c0d0e0f,
               lat: 3, hold: 1, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    for (int i = 2; i < 4; i++) begin
      tbl[i].pt   = {$urandom(), $urandom(), $urandom(), $urandom()};
      tbl[i].key  = {$urandom(), $urandom(), $urandom(), $urandom()};
      tbl[i].lat  = 4 - i;
      tbl[i].hold = 3;
      tbl[i].ct   = ref_encrypt(tbl[i].pt, expand(tbl[i].key));
    end

    repeat (3) @(negedge clk);
    chk("reset_ctrl", {enableRounds, initialRound, finalRound, done, busy, valid, error}, 7'd0);
    chk("reset_cipher", ciphertext, 128'd0);
    chk("reset_msg", messageIn, 128'd0);
    rst = 1'b1;

    // table: known-answer and random vectors with varied latency / roundDone hold
    for (int i = 0; i < 4; i++) begin
      dp_lat = tbl[i].lat;
      dp_hold = tbl[i].hold;
      load_key(tbl[i].key);
      start_enc(tbl[i].pt, tbl[i].ct, 1'b1);
      wait_enc();
    end

    // start while busy is ignored, then a back-to-back start is accepted
    dp_lat = 1;
    dp_hold = 1;
    load_key(KEY_B);
    start_enc(PT_B, CT_B, 1'b1);
    repeat (3) @(negedge clk);
    chk("busy_mid", busy, 1'b1);
    start = 1'b1;
    plaintext = 128'h00112233445566778899aabbccddeeff;
    @(negedge clk);
    start = 1'b0;
    wait_enc();
    pt_r = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_enc(pt_r, ref_encrypt(pt_r, expandedKey), 1'b1);
    wait_enc();

    // datapath stalls in round 4: timeout after TMO cycles, no valid
    withhold = 1'b1;
    start_enc(PT_B, CT_B, 1'b0);
    k = 0;
    while (!error && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("timeout_error", error, 1'b1);
    chk("timeout_len", en_len, TMO);
    chk("timeout_round", en_periods, 5);
    chk("timeout_idle", {busy, enableRounds, valid, done}, 4'd0);
    withhold = 1'b0;
    repeat (3) @(negedge clk);
    chk("error_sticky", error, 1'b1);
    start_enc(PT_B, CT_B, 1'b1);
    #1;
    chk("error_clear", error, 1'b0);
    wait_enc();

    // asynchronous reset between edges during round 6
    start_enc(PT_B, CT_B, 1'b1);
    k = 0;
    while (en_periods < 7 && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("reached_round6", en_periods, 7);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ctrl", {enableRounds, initialRound, finalRound, done, busy, valid, error}, 7'd0);
    chk("arst_cipher", ciphertext, 128'd0);
    chk("arst_msg", messageIn, 128'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pt_r = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_enc(pt_r, ref_encrypt(pt_r, expandedKey), 1'b1);
    wait_enc();

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
